// File: rtl/axil_register_slice_if.sv
// ---------------------------------------------------------------------------
// axil_pkg / axil_if
//
// axil_pkg holds the AXI-Lite payload widths shared by the link and by the
// register slice, plus the skid-buffer state encoding. That encoding is also
// visible on the slice debug output.
//
// axil_if is one AXI-Lite link: the AW, W, B, AR and R channels.
//   modport m_axil : the master end of the link.
//                    It drives AW/W/AR payload and valid, and B/R ready.
//   modport s_axil : the slave end of the link.
//                    It drives AW/W/AR ready, and B/R payload and valid.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high. A source holds its valid and payload
// stable until that beat transfers. A sink may change its ready at any time.
// ---------------------------------------------------------------------------
package axil_pkg;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_RESP_WIDTH = 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;
endpackage

interface axil_if;
  import axil_pkg::*;

  logic                      awvalid;
  logic                      awready;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;

  logic                      wvalid;
  logic                      wready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;

  logic                      bvalid;
  logic                      bready;
  logic [AXI_RESP_WIDTH-1:0] bresp;

  logic                      arvalid;
  logic                      arready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;

  logic                      rvalid;
  logic                      rready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [AXI_RESP_WIDTH-1:0] rresp;

  modport m_axil (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport s_axil (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_register_slice.sv
// ---------------------------------------------------------------------------
// axil_register_slice
//
// Per-channel AXI-Lite pipeline stage. It sits on one interconnect master link
// and cuts every combinational valid/ready/payload path through that link.
// Each buffered channel is a 2-entry skid buffer. It sustains one beat per
// cycle per channel, and its valid and ready outputs both come straight from
// flops.
//
// Parameters (1 = skid-buffered, 0 = plain wires):
//   REG_AW, REG_W, REG_AR  request channels, s_axil -> m_axil
//   REG_B,  REG_R          response channels, m_axil -> s_axil
//
// Ports:
//   aclk       clock; all logic runs on the rising edge
//   areset     synchronous, active-high reset
//   s_axil     upstream side, driven by the interconnect master port
//   m_axil     downstream side, toward the AXI-Lite slave
//   wr_cnt     count of s-side B handshakes  (only with AXIL_SLICE_CNT_EN)
//   rd_cnt     count of s-side R handshakes  (only with AXIL_SLICE_CNT_EN)
//   dbg_state  skid FSM states, packed as {r, ar, b, w, aw}, 2 bits each.
//              A pass-through channel always reads SKID_EMPTY.
//
// Optional feature: define AXIL_SLICE_CNT_EN to add the wr_cnt/rd_cnt
// transaction counters. Both counters wrap silently and clear on reset.
//
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both high. The source holds its valid and payload stable
// until the beat transfers.
// ---------------------------------------------------------------------------

// One skid unit.
//   EMPTY: out_valid=0, in_ready=1.
//   ONE:   main holds a beat; out_valid=1, in_ready=1.
//   TWO:   main and skid both hold a beat; out_valid=1, in_ready=0.
// in_ready and out_valid are registered copies of the next state. They clear
// on reset, and in_ready only rises on the first edge after reset is released.
// The payload registers are never reset: whenever they hold stale data, the
// matching valid is low.
module axil_register_slice_skid
  import axil_pkg::*;
#(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [W-1:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [W-1:0] out_data,
  output skid_state_e state
);
  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         in_hs, out_hs;

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_hs) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_hs && out_hs) begin
          // main drains and reloads in the same edge: full throughput
          main_d = in_data;
        end else if (in_hs) begin
          // downstream stalled: the new beat parks in skid behind main
          skid_d  = in_data;
          state_d = SKID_TWO;
        end else if (out_hs) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only the output side can move
        if (out_hs) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    in_ready_d  = (state_d != SKID_TWO);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign state     = state_q;
endmodule

module axil_register_slice
  import axil_pkg::*;
#(
  parameter bit REG_AW = 1'b1,
  parameter bit REG_W  = 1'b1,
  parameter bit REG_B  = 1'b1,
  parameter bit REG_AR = 1'b1,
  parameter bit REG_R  = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  axil_if.s_axil      s_axil,
  axil_if.m_axil      m_axil,
`ifdef AXIL_SLICE_CNT_EN
  output logic [31:0] wr_cnt,
  output logic [31:0] rd_cnt,
`endif
  output logic [9:0]  dbg_state
);
  localparam int W_W = AXI_DATA_WIDTH + AXI_STRB_WIDTH;
  localparam int R_W = AXI_DATA_WIDTH + AXI_RESP_WIDTH;

  skid_state_e aw_state, w_state, b_state, ar_state, r_state;

  // AW: s -> m
  if (REG_AW) begin : g_aw
    axil_register_slice_skid #(.W(AXI_ADDR_WIDTH)) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .in_valid (s_axil.awvalid),
      .in_ready (s_axil.awready),
      .in_data  (s_axil.awaddr),
      .out_valid(m_axil.awvalid),
      .out_ready(m_axil.awready),
      .out_data (m_axil.awaddr),
      .state    (aw_state)
    );
  end else begin : g_aw_pt
    assign m_axil.awvalid = s_axil.awvalid;
    assign s_axil.awready = m_axil.awready;
    assign m_axil.awaddr  = s_axil.awaddr;
    assign aw_state       = SKID_EMPTY;
  end

  // W: s -> m, with data and strobe carried together as one payload
  if (REG_W) begin : g_w
    logic [W_W-1:0] w_in, w_out;
    assign w_in = {s_axil.wdata, s_axil.wstrb};
    assign {m_axil.wdata, m_axil.wstrb} = w_out;
    axil_register_slice_skid #(.W(W_W)) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .in_valid (s_axil.wvalid),
      .in_ready (s_axil.wready),
      .in_data  (w_in),
      .out_valid(m_axil.wvalid),
      .out_ready(m_axil.wready),
      .out_data (w_out),
      .state    (w_state)
    );
  end else begin : g_w_pt
    assign m_axil.wvalid = s_axil.wvalid;
    assign s_axil.wready = m_axil.wready;
    assign m_axil.wdata  = s_axil.wdata;
    assign m_axil.wstrb  = s_axil.wstrb;
    assign w_state       = SKID_EMPTY;
  end

  // B: m -> s
  if (REG_B) begin : g_b
    axil_register_slice_skid #(.W(AXI_RESP_WIDTH)) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .in_valid (m_axil.bvalid),
      .in_ready (m_axil.bready),
      .in_data  (m_axil.bresp),
      .out_valid(s_axil.bvalid),
      .out_ready(s_axil.bready),
      .out_data (s_axil.bresp),
      .state    (b_state)
    );
  end else begin : g_b_pt
    assign s_axil.bvalid = m_axil.bvalid;
    assign m_axil.bready = s_axil.bready;
    assign s_axil.bresp  = m_axil.bresp;
    assign b_state       = SKID_EMPTY;
  end

  // AR: s -> m
  if (REG_AR) begin : g_ar
    axil_register_slice_skid #(.W(AXI_ADDR_WIDTH)) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .in_valid (s_axil.arvalid),
      .in_ready (s_axil.arready),
      .in_data  (s_axil.araddr),
      .out_valid(m_axil.arvalid),
      .out_ready(m_axil.arready),
      .out_data (m_axil.araddr),
      .state    (ar_state)
    );
  end else begin : g_ar_pt
    assign m_axil.arvalid = s_axil.arvalid;
    assign s_axil.arready = m_axil.arready;
    assign m_axil.araddr  = s_axil.araddr;
    assign ar_state       = SKID_EMPTY;
  end

  // R: m -> s, with data and response carried together as one payload
  if (REG_R) begin : g_r
    logic [R_W-1:0] r_in, r_out;
    assign r_in = {m_axil.rdata, m_axil.rresp};
    assign {s_axil.rdata, s_axil.rresp} = r_out;
    axil_register_slice_skid #(.W(R_W)) u_skid (
      .clk      (aclk),
      .rst      (areset),
      .in_valid (m_axil.rvalid),
      .in_ready (m_axil.rready),
      .in_data  (r_in),
      .out_valid(s_axil.rvalid),
      .out_ready(s_axil.rready),
      .out_data (r_out),
      .state    (r_state)
    );
  end else begin : g_r_pt
    assign s_axil.rvalid = m_axil.rvalid;
    assign m_axil.rready = s_axil.rready;
    assign s_axil.rdata  = m_axil.rdata;
    assign s_axil.rresp  = m_axil.rresp;
    assign r_state       = SKID_EMPTY;
  end

  assign dbg_state = {r_state, ar_state, b_state, w_state, aw_state};

`ifdef AXIL_SLICE_CNT_EN
  // Completed transactions as seen by the upstream master. Every response
  // counts, whatever its resp code.
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (s_axil.bvalid && s_axil.bready) wr_cnt_d = wr_cnt_q + 32'd1;
    if (s_axil.rvalid && s_axil.rready) rd_cnt_d = rd_cnt_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_cnt_q <= 32'd0;
      rd_cnt_q <= 32'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_axil_register_slice.sv
// ---------------------------------------------------------------------------
// tb_axil_register_slice
//
// Directed bench for axil_register_slice. It uses two instances:
//   dut     every channel skid-buffered
//   dut_pt  B and R wired straight through (REG_B=0, REG_R=0)
// Inputs are driven 1 time unit after each rising edge. DUT outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_axil_register_slice;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [9:0] dbg_state, dbg_state2;
`ifdef AXIL_SLICE_CNT_EN
  logic [31:0] wr_cnt, rd_cnt, wr_cnt2, rd_cnt2;
`endif

  axil_if s_if ();
  axil_if m_if ();
  axil_if s2_if ();
  axil_if m2_if ();

  always #5 aclk = ~aclk;

  axil_register_slice dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_axil   (s_if),
    .m_axil   (m_if),
`ifdef AXIL_SLICE_CNT_EN
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt),
`endif
    .dbg_state(dbg_state)
  );

  axil_register_slice #(.REG_B(1'b0), .REG_R(1'b0)) dut_pt (
    .aclk     (aclk),
    .areset   (areset),
    .s_axil   (s2_if),
    .m_axil   (m2_if),
`ifdef AXIL_SLICE_CNT_EN
    .wr_cnt   (wr_cnt2),
    .rd_cnt   (rd_cnt2),
`endif
    .dbg_state(dbg_state2)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_idle();
    s_if.awvalid = 0; s_if.awaddr = '0; s_if.wvalid = 0; s_if.wdata = '0; s_if.wstrb = '0;
    s_if.bready = 0; s_if.arvalid = 0; s_if.araddr = '0; s_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = '0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = '0;
    s2_if.awvalid = 0; s2_if.awaddr = '0; s2_if.wvalid = 0; s2_if.wdata = '0; s2_if.wstrb = '0;
    s2_if.bready = 0; s2_if.arvalid = 0; s2_if.araddr = '0; s2_if.rready = 0;
    m2_if.awready = 0; m2_if.wready = 0; m2_if.bvalid = 0; m2_if.bresp = '0;
    m2_if.arready = 0; m2_if.rvalid = 0; m2_if.rdata = '0; m2_if.rresp = '0;
  endtask

  task automatic test_reset();
    logic [4:0] valids, readies;
    areset = 1;
    drive_idle();
    tick();
    tick();
    valids  = {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid};
    readies = {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready};
    checks++;
    if (valids !== 5'b0) begin
      failures++; $display("FAIL reset_valids got=%b exp=%b", valids, 5'b0);
    end
    checks++;
    if (readies !== 5'b0) begin
      failures++; $display("FAIL reset_readies got=%b exp=%b", readies, 5'b0);
    end
    areset = 0;
    tick();
    readies = {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready};
    checks++;
    if (readies !== 5'b11111) begin
      failures++; $display("FAIL post_reset_readies got=%b exp=%b", readies, 5'b11111);
    end
    checks++;
    if (dbg_state !== 10'd0) begin
      failures++; $display("FAIL post_reset_state got=%h exp=%h", dbg_state, 10'd0);
    end
  endtask

  task automatic test_write();
    // cycle 0: AW and W offered together, and the slave is ready
    s_if.awvalid = 1; s_if.awaddr = 32'h0000_0010;
    s_if.wvalid = 1; s_if.wdata = 32'hDEAD_BEEF; s_if.wstrb = 4'hF;
    m_if.awready = 1; m_if.wready = 1; s_if.bready = 1;
    checks++;
    if (m_if.awvalid !== 1'b0) begin
      failures++; $display("FAIL wr_aw_early got=%b exp=0", m_if.awvalid);
    end
    tick();
    s_if.awvalid = 0; s_if.wvalid = 0;
    checks++;
    if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h0000_0010) begin
      failures++; $display("FAIL wr_aw_out got=%b/%h exp=1/00000010", m_if.awvalid, m_if.awaddr);
    end
    checks++;
    if (m_if.wvalid !== 1'b1 || m_if.wdata !== 32'hDEAD_BEEF || m_if.wstrb !== 4'hF) begin
      failures++; $display("FAIL wr_w_out got=%b/%h/%h exp=1/deadbeef/f", m_if.wvalid, m_if.wdata, m_if.wstrb);
    end
    tick();
    checks++;
    if (m_if.awvalid !== 1'b0 || m_if.wvalid !== 1'b0) begin
      failures++; $display("FAIL wr_no_dup got=%b%b exp=00", m_if.awvalid, m_if.wvalid);
    end
    // the slave answers with OKAY
    m_if.bvalid = 1; m_if.bresp = 2'b00;
    checks++;
    if (s_if.bvalid !== 1'b0) begin
      failures++; $display("FAIL wr_b_early got=%b exp=0", s_if.bvalid);
    end
    tick();
    m_if.bvalid = 0;
    checks++;
    if (s_if.bvalid !== 1'b1 || s_if.bresp !== 2'b00) begin
      failures++; $display("FAIL wr_b_out got=%b/%b exp=1/00", s_if.bvalid, s_if.bresp);
    end
    tick();
    checks++;
    if (s_if.bvalid !== 1'b0) begin
      failures++; $display("FAIL wr_b_done got=%b exp=0", s_if.bvalid);
    end
    drive_idle();
  endtask

  task automatic test_read_stream();
    int sent, got, drops, last_accept;
    logic pend_v, nxt_v;
    logic [31:0] pend_d, nxt_d, exp;
    sent = 0; got = 0; drops = 0; last_accept = -1;
    pend_v = 0; pend_d = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      s_if.arvalid = (sent < 8);
      s_if.araddr = 32'h100 + 32'(sent) * 4;
      m_if.arready = 1; s_if.rready = 1;
      // the slave returns R data one cycle after each AR it accepts
      m_if.rvalid = pend_v; m_if.rdata = pend_d; m_if.rresp = 2'b00;
      if (s_if.arvalid && !s_if.arready) drops++;
      nxt_v = pend_v && !m_if.rready;
      nxt_d = pend_d;
      if (m_if.arvalid && m_if.arready) begin
        nxt_v = 1; nxt_d = m_if.araddr ^ 32'hCAFE_0000;
      end
      if (s_if.rvalid && s_if.rready) begin
        exp = (32'h100 + 32'(got) * 4) ^ 32'hCAFE_0000;
        checks++;
        if (s_if.rdata !== exp) begin
          failures++; $display("FAIL rd_data[%0d] got=%h exp=%h", got, s_if.rdata, exp);
        end
        got++;
      end
      if (s_if.arvalid && s_if.arready) begin
        sent++; last_accept = cyc;
      end
      pend_v = nxt_v; pend_d = nxt_d;
      tick();
    end
    drive_idle();
    checks++;
    if (drops !== 0) begin
      failures++; $display("FAIL rd_arready_drop got=%0d exp=0", drops);
    end
    checks++;
    if (last_accept !== 7) begin
      failures++; $display("FAIL rd_accept_cycle got=%0d exp=7", last_accept);
    end
    checks++;
    if (got !== 8) begin
      failures++; $display("FAIL rd_count got=%0d exp=8", got);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a [3];
    int in_idx, out_idx;
    a[0] = 32'h200; a[1] = 32'h204; a[2] = 32'h208;
    in_idx = 0; out_idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      m_if.arready = (cyc >= 3);
      s_if.arvalid = (in_idx < 3);
      s_if.araddr = (in_idx < 3) ? a[in_idx] : 32'h0;
      if (cyc == 2) begin
        checks++;
        if (s_if.arready !== 1'b0) begin
          failures++; $display("FAIL bp_arready got=%b exp=0", s_if.arready);
        end
        checks++;
        if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h200) begin
          failures++; $display("FAIL bp_main got=%b/%h exp=1/00000200", m_if.arvalid, m_if.araddr);
        end
        checks++;
        if (dbg_state[7:6] !== 2'd2) begin
          failures++; $display("FAIL bp_state got=%0d exp=2", dbg_state[7:6]);
        end
      end
      if (m_if.arvalid && m_if.arready) begin
        checks++;
        if (out_idx >= 3) begin
          failures++; $display("FAIL bp_extra_beat got=%h exp=none", m_if.araddr);
        end else if (m_if.araddr !== a[out_idx]) begin
          failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", out_idx, m_if.araddr, a[out_idx]);
        end
        out_idx++;
      end
      if (s_if.arvalid && s_if.arready) in_idx++;
      tick();
    end
    drive_idle();
    checks++;
    if (out_idx !== 3) begin
      failures++; $display("FAIL bp_count got=%0d exp=3", out_idx);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] valids, readies;
    int seen;
    m_if.wready = 0;
    s_if.wvalid = 1; s_if.wdata = 32'h1111_1111; s_if.wstrb = 4'hF;
    tick();
    s_if.wdata = 32'h2222_2222;
    tick();
    s_if.wvalid = 0;
    checks++;
    if (dbg_state[3:2] !== 2'd2 || s_if.wready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_two got=%0d/%b exp=2/0", dbg_state[3:2], s_if.wready);
    end
    areset = 1;
    tick();
    valids  = {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid};
    readies = {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready};
    checks++;
    if (valids !== 5'b0 || readies !== 5'b0) begin
      failures++; $display("FAIL rst_mid_clear got=%b/%b exp=00000/00000", valids, readies);
    end
    areset = 0;
    m_if.wready = 1;
    tick();
    readies = {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready};
    checks++;
    if (readies !== 5'b11111) begin
      failures++; $display("FAIL rst_mid_ready got=%b exp=11111", readies);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_if.wvalid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL rst_mid_stale got=%0d exp=0", seen);
    end
    drive_idle();
  endtask

  task automatic test_pass_through();
    m2_if.bvalid = 1; m2_if.bresp = 2'b10; s2_if.bready = 0;
    #1;
    checks++;
    if (s2_if.bvalid !== 1'b1 || s2_if.bresp !== 2'b10) begin
      failures++; $display("FAIL pt_b got=%b/%b exp=1/10", s2_if.bvalid, s2_if.bresp);
    end
    s2_if.bready = 1;
    #1;
    checks++;
    if (m2_if.bready !== 1'b1) begin
      failures++; $display("FAIL pt_bready got=%b exp=1", m2_if.bready);
    end
    m2_if.bvalid = 0;
    #1;
    checks++;
    if (s2_if.bvalid !== 1'b0) begin
      failures++; $display("FAIL pt_b_drop got=%b exp=0", s2_if.bvalid);
    end
    tick();
    drive_idle();
  endtask

`ifdef AXIL_SLICE_CNT_EN
  task automatic test_counters();
    areset = 1;
    tick();
    areset = 0;
    tick();
    s_if.bready = 1; s_if.rready = 1;
    for (int i = 0; i < 5; i++) begin
      m_if.bvalid = 1; m_if.bresp = (i == 2) ? 2'b10 : 2'b00;
      tick();
    end
    m_if.bvalid = 0;
    for (int i = 0; i < 3; i++) begin
      m_if.rvalid = 1; m_if.rdata = 32'(i); m_if.rresp = 2'b00;
      tick();
    end
    m_if.rvalid = 0;
    tick(); tick(); tick();
    checks++;
    if (wr_cnt !== 32'd5) begin
      failures++; $display("FAIL cnt_wr got=%0d exp=5", wr_cnt);
    end
    checks++;
    if (rd_cnt !== 32'd3) begin
      failures++; $display("FAIL cnt_rd got=%0d exp=3", rd_cnt);
    end
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    m_if.bvalid = 1; m_if.bresp = 2'b00;
    tick();
    m_if.bvalid = 0;
    tick(); tick();
    checks++;
    if (wr_cnt !== 32'd0) begin
      failures++; $display("FAIL cnt_wrap got=%h exp=00000000", wr_cnt);
    end
    drive_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_stream();
    test_backpressure();
    test_reset_mid();
    test_pass_through();
`ifdef AXIL_SLICE_CNT_EN
    test_counters();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
